// File: rtl/alu_seq.sv
// alu_seq: registered, handshaked ALU with a 3-bit opcode space.
//
// Opcodes:
//   000 ADD, 001 PASS0, 010 INC, 011 PASS1, 100 SUB, 101 AND, 110 XOR, 111 MUL
//
// Build option:
//   ALU_MUL_EN defined   : opcode 111 is a DATA_WIDTH-cycle shift-add multiply.
//   ALU_MUL_EN undefined : no multiplier is built. Opcode 111 completes in one
//                          cycle with OUT=0, ZF=1, CF=0, and BUSY is tied to 0.
//
// Ports:
//   CLK   - clock, all state on the rising edge
//   RST   - synchronous, active-high reset
//   START - request. Accepted only when the FSM is idle.
//   OP    - opcode, sampled on an accepted START
//   IN0   - operand A, sampled on an accepted START
//   IN1   - operand B, sampled on an accepted START
//   OUT   - registered result, held until the next completion
//   ZF    - zero flag (OUT == 0), updated together with OUT
//   CF    - carry/borrow flag (for MUL: high half of product nonzero)
//   BUSY  - multiply in progress
//   DONE  - one-cycle pulse marking a newly updated OUT/ZF/CF
//
// State table (ALU_MUL_EN build):
//   state  | meaning
//   S_IDLE | waiting for START; single-cycle ops complete straight from here
//   S_MUL  | shift-add multiply running, one multiplier bit per cycle
module alu_seq #(
  parameter int DATA_WIDTH = 4,
  parameter int OP_WIDTH   = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [OP_WIDTH-1:0]   OP,
  input  logic [DATA_WIDTH-1:0] IN0,
  input  logic [DATA_WIDTH-1:0] IN1,
  output logic [DATA_WIDTH-1:0] OUT,
  output logic                  ZF,
  output logic                  CF,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam logic [OP_WIDTH-1:0] OP_ADD   = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_PASS0 = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_INC   = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_PASS1 = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OP_SUB   = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OP_AND   = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] OP_XOR   = OP_WIDTH'(6);

  // One extra bit on each arithmetic path holds carry (ADD/INC) or
  // borrow (SUB: the MSB is set exactly when IN0 < IN1 unsigned).
  logic [DATA_WIDTH:0]   add_w;
  logic [DATA_WIDTH:0]   inc_w;
  logic [DATA_WIDTH:0]   sub_w;
  logic [DATA_WIDTH-1:0] sc_out;
  logic                  sc_cf;

  assign add_w = {1'b0, IN0} + {1'b0, IN1};
  assign inc_w = {1'b0, IN0} + (DATA_WIDTH+1)'(1);
  assign sub_w = {1'b0, IN0} - {1'b0, IN1};

  // Single-cycle result. Opcode 111 falls to the default (0, no carry),
  // which is the full behaviour when no multiplier is built.
  always_comb begin
    sc_out = '0;
    sc_cf  = 1'b0;
    case (OP)
      OP_ADD:   begin sc_out = add_w[DATA_WIDTH-1:0]; sc_cf = add_w[DATA_WIDTH]; end
      OP_PASS0: sc_out = IN0;
      OP_INC:   begin sc_out = inc_w[DATA_WIDTH-1:0]; sc_cf = inc_w[DATA_WIDTH]; end
      OP_PASS1: sc_out = IN1;
      OP_SUB:   begin sc_out = sub_w[DATA_WIDTH-1:0]; sc_cf = sub_w[DATA_WIDTH]; end
      OP_AND:   sc_out = IN0 & IN1;
      OP_XOR:   sc_out = IN0 ^ IN1;
      default:  ;
    endcase
  end

`ifdef ALU_MUL_EN

  localparam logic [OP_WIDTH-1:0] OP_MUL = OP_WIDTH'(7);
  localparam int                  CW     = $clog2(DATA_WIDTH + 1);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [2*DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0]   mcand;
  logic [DATA_WIDTH:0]     mul_sum;
  logic [2*DATA_WIDTH-1:0] acc_next;

  // acc holds {partial product, remaining multiplier bits}. Each step adds
  // the multiplicand into the upper half when the current multiplier LSB is
  // set, then shifts right by one with the add's carry entering at the top.
  // After DATA_WIDTH steps acc is the full product.
  assign mul_sum  = {1'b0, acc[2*DATA_WIDTH-1:DATA_WIDTH]}
                  + {1'b0, (acc[0] ? mcand : {DATA_WIDTH{1'b0}})};
  assign acc_next = {mul_sum, acc[DATA_WIDTH-1:1]};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
      cnt   <= '0;
      acc   <= '0;
      mcand <= '0;
      OUT   <= '0;
      ZF    <= 1'b0;
      CF    <= 1'b0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START) begin
            if (OP == OP_MUL) begin
              state <= S_MUL;
              cnt   <= CW'(DATA_WIDTH);
              acc   <= {{DATA_WIDTH{1'b0}}, IN1};
              mcand <= IN0;
              BUSY  <= 1'b1;
            end else begin
              OUT  <= sc_out;
              ZF   <= (sc_out == '0);
              CF   <= sc_cf;
              DONE <= 1'b1;
            end
          end
        end
        S_MUL: begin
          acc <= acc_next;
          cnt <= cnt - CW'(1);
          // BUSY drops one cycle ahead of DONE so it is high for
          // DATA_WIDTH-1 cycles; START is still refused until IDLE.
          if (cnt == CW'(2)) begin
            BUSY <= 1'b0;
          end
          if (cnt == CW'(1)) begin
            OUT   <= acc_next[DATA_WIDTH-1:0];
            ZF    <= (acc_next[DATA_WIDTH-1:0] == '0);
            CF    <= (acc_next[2*DATA_WIDTH-1:DATA_WIDTH] != '0);
            DONE  <= 1'b1;
            BUSY  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

`else

  // No multi-cycle work exists, so every START completes on its own edge.
  assign BUSY = 1'b0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      OUT  <= '0;
      ZF   <= 1'b0;
      CF   <= 1'b0;
      DONE <= 1'b0;
    end else begin
      DONE <= START;
      if (START) begin
        OUT <= sc_out;
        ZF  <= (sc_out == '0);
        CF  <= sc_cf;
      end
    end
  end

`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at DATA_WIDTH=4. Expected results come from a
// small reference model, are queued when START is driven and are compared
// when DONE is observed.
module tb_alu_seq;

  localparam int DW = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          START;
  logic [2:0]    OP;
  logic [DW-1:0] IN0;
  logic [DW-1:0] IN1;
  logic [DW-1:0] OUT;
  logic          ZF;
  logic          CF;
  logic          BUSY;
  logic          DONE;

  int n_checks = 0;
  int n_pass   = 0;
  int n_done   = 0;
  int n_issued = 0;

  logic [5:0] sb[$];
  logic [5:0] last_exp;

  alu_seq #(.DATA_WIDTH(DW), .OP_WIDTH(3)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .OP    (OP),
    .IN0   (IN0),
    .IN1   (IN1),
    .OUT   (OUT),
    .ZF    (ZF),
    .CF    (CF),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference model: returns {OUT, ZF, CF}.
  function automatic logic [5:0] model(input logic [2:0] op, input int a, input int b);
    int   r;
    logic c;
    r = 0;
    c = 1'b0;
    case (op)
      3'd0: begin r = a + b; c = (r > 15); end
      3'd1: r = a;
      3'd2: begin r = a + 1; c = (r > 15); end
      3'd3: r = b;
      3'd4: begin r = a - b; c = (a < b); end
      3'd5: r = a & b;
      3'd6: r = a ^ b;
      default: begin
`ifdef ALU_MUL_EN
        r = a * b;
        c = (r > 15);
`else
        r = 0;
`endif
      end
    endcase
    return {r[3:0], (r[3:0] == 4'd0), c};
  endfunction

  // Scoreboard consumer.
  always @(negedge CLK) begin
    if (!RST && DONE) begin
      n_done++;
      check("done_has_expectation", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        logic [5:0] e;
        e = sb.pop_front();
        check("result_out_zf_cf", {26'd0, OUT, ZF, CF}, {26'd0, e});
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    OP    = op;
    IN0   = a;
    IN1   = b;
    START = 1'b1;
    last_exp = model(op, a, b);
    sb.push_back(last_exp);
    n_issued++;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic single(input string tag, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    issue(op, a, b);
    check({tag, "_done"}, 32'(DONE), 32'd1);
    check({tag, "_busy"}, 32'(BUSY), 32'd0);
    @(posedge CLK); #1;
    check({tag, "_done_pulse"}, 32'(DONE), 32'd0);
    check({tag, "_hold"}, {26'd0, OUT, ZF, CF}, {26'd0, last_exp});
  endtask

`ifdef ALU_MUL_EN
  task automatic mul_run(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input bit interfere);
    logic [5:0] prev;
    int         lat;
    int         busy_n;
    bit         got;
    prev = last_exp;
    issue(3'd7, a, b);
    check({tag, "_busy_at_accept"}, 32'(BUSY), 32'd1);
    busy_n = int'(BUSY);
    lat    = 0;
    got    = 1'b0;
    if (interfere) begin
      START = 1'b1;
      OP    = 3'd0;
      IN0   = 4'd1;
      IN1   = 4'd1;
    end
    while (!got && lat < 20) begin
      check({tag, "_hold"}, {26'd0, OUT, ZF, CF}, {26'd0, prev});
      @(posedge CLK); #1;
      lat++;
      if (DONE) begin
        got   = 1'b1;
        START = 1'b0;
      end else begin
        busy_n += int'(BUSY);
      end
    end
    START = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'(DW));
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'(DW - 1));
    check({tag, "_busy_at_done"}, 32'(BUSY), 32'd0);
    @(posedge CLK); #1;
    check({tag, "_done_pulse"}, 32'(DONE), 32'd0);
  endtask
`endif

  initial begin
    int d0;
    RST   = 1'b1;
    START = 1'b0;
    OP    = 3'd0;
    IN0   = '0;
    IN1   = '0;
    last_exp = 6'd0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_out",  32'(OUT),  32'd0);
    check("rst_zf",   32'(ZF),   32'd0);
    check("rst_cf",   32'(CF),   32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    RST = 1'b0;
    @(posedge CLK); #1;

    single("add_9_8", 3'd0, 4'd9, 4'd8);

    // INC 15, then SUB 3-5 accepted on the DONE cycle of the INC.
    OP = 3'd2; IN0 = 4'd15; IN1 = 4'd0; START = 1'b1;
    last_exp = model(3'd2, 15, 0); sb.push_back(last_exp); n_issued++;
    @(posedge CLK); #1;
    check("b2b_inc_done", 32'(DONE), 32'd1);
    OP = 3'd4; IN0 = 4'd3; IN1 = 4'd5;
    last_exp = model(3'd4, 3, 5); sb.push_back(last_exp); n_issued++;
    @(posedge CLK); #1;
    START = 1'b0;
    check("b2b_sub_done", 32'(DONE), 32'd1);
    check("b2b_sub_out", 32'(OUT), 32'd14);
    @(posedge CLK); #1;

    single("pass0",    3'd1, 4'd10, 4'd3);
    single("pass1",    3'd3, 4'd10, 4'd3);
    single("and",      3'd5, 4'd12, 4'd10);
    single("xor",      3'd6, 4'd12, 4'd10);
    single("xor_zero", 3'd6, 4'd9,  4'd9);
    single("sub_eq",   3'd4, 4'd7,  4'd7);
    single("add_max",  3'd0, 4'd15, 4'd15);
    single("sub_wrap", 3'd4, 4'd0,  4'd1);

    // Reset wins over a simultaneous START.
    OP = 3'd0; IN0 = 4'd1; IN1 = 4'd1; START = 1'b1; RST = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0; RST = 1'b0;
    check("rst_vs_start_done", 32'(DONE), 32'd0);
    check("rst_vs_start_out", {26'd0, OUT, ZF, CF}, 32'd0);
    last_exp = 6'd0;

`ifdef ALU_MUL_EN
    single("pre_mul_add", 3'd0, 4'd2, 4'd4);
    mul_run("mul_7_3", 4'd7, 4'd3, 1'b0);
    mul_run("mul_interfere", 4'd7, 4'd3, 1'b1);
    mul_run("mul_zero", 4'd0, 4'd9, 1'b0);
    mul_run("mul_15_15", 4'd15, 4'd15, 1'b0);

    // Abort a multiply with reset two cycles after acceptance.
    single("pre_abort_add", 3'd0, 4'd6, 4'd5);
    issue(3'd7, 4'd7, 4'd3);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    sb.delete();
    n_issued--;
    check("abort_out_flags", {26'd0, OUT, ZF, CF}, 32'd0);
    check("abort_busy", 32'(BUSY), 32'd0);
    check("abort_done", 32'(DONE), 32'd0);
    d0 = n_done;
    repeat (8) @(posedge CLK);
    #1;
    check("abort_no_done", 32'(n_done), 32'(d0));
    last_exp = 6'd0;
`else
    single("op111_nomul", 3'd7, 4'd7, 4'd3);
    check("op111_zf", 32'(ZF), 32'd1);
`endif

    repeat (3) @(posedge CLK);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("done_count", 32'(n_done), 32'(n_issued));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
